// File: rtl/dii_packet_arbiter_pkg.sv
// Shared DII channel definitions: flit layout and arbiter state encoding.
package osd_dii_pkg;

    localparam int DII_DATA_W = 16;

    typedef struct packed {
        logic [DII_DATA_W-1:0] data;
        logic                  first;
        logic                  last;
    } dii_flit_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dii_packet_arbiter_if.sv
// One DII channel: the master drives the flit and valid, the slave returns ready.
interface dii_channel;
    import osd_dii_pkg::*;

    logic [DII_DATA_W-1:0] data;
    logic                  first;
    logic                  last;
    logic                  valid;
    logic                  ready;

    modport master (output data, first, last, valid, input ready);
    modport slave  (input data, first, last, valid, output ready);

endinterface

// File: rtl/dii_packet_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr_i, wrapping modulo N.
module osd_rr_pick #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [PTR_W-1:0] gnt_idx_o,
    output logic             gnt_valid_o
);

    int idx;

    always_comb begin
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        idx         = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= N) idx = idx - N;
            if (!gnt_valid_o && req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/dii_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one downstream DII channel among N upstream channels.
module dii_packet_arbiter
    import osd_dii_pkg::*;
#(
    parameter int  N     = 2,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    dii_channel.slave        in_i [N],
    dii_channel.master       out_o,
    output logic             busy_o,
    output logic [PTR_W-1:0] grant_id_o
);

    arb_state_e       state_q, state_d;
    logic [PTR_W-1:0] grant_q, grant_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [N-1:0]     req;
    logic [N-1:0]     valid_v;
    logic [N-1:0]     ready_v;
    dii_flit_t        flit_v [N];
    dii_flit_t        out_flit;
    logic             out_valid;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_valid;

    // Only the head flit of a packet may win arbitration.
    for (genvar g = 0; g < N; g++) begin : g_in
        assign req[g]         = in_i[g].valid & in_i[g].first;
        assign valid_v[g]     = in_i[g].valid;
        assign flit_v[g]      = {in_i[g].data, in_i[g].first, in_i[g].last};
        assign in_i[g].ready  = ready_v[g];
    end

    osd_rr_pick #(.N(N), .PTR_W(PTR_W)) u_pick (
        .req_i       (req),
        .ptr_i       (rr_ptr_q),
        .gnt_idx_o   (pick_idx),
        .gnt_valid_o (pick_valid)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        out_flit  = '0;
        out_valid = 1'b0;
        ready_v   = '0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_d = pick_idx;
                        state_d = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    out_flit         = flit_v[grant_q];
                    out_valid        = valid_v[grant_q];
                    ready_v[grant_q] = out_o.ready;
                    if (out_valid && out_o.ready && out_flit.last) begin
                        rr_ptr_d = (grant_q == PTR_W'(N - 1)) ? '0 : grant_q + PTR_W'(1);
                        state_d  = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign out_o.data  = out_flit.data;
    assign out_o.first = out_flit.first;
    assign out_o.last  = out_flit.last;
    assign out_o.valid = out_valid;

    assign busy_o     = !rst && (state_q == ST_BUSY);
    assign grant_id_o = rst ? '0 : grant_q;

endmodule

// File: tb/tb_dii_packet_arbiter.sv
// Scoreboard bench for dii_packet_arbiter with three requesters and directed packet vectors.
module tb_dii_packet_arbiter;
    import osd_dii_pkg::*;

    localparam int N     = 3;
    localparam int PTR_W = 2;

    typedef struct {
        logic [15:0] data;
        logic        first;
        logic        last;
        int          hold;
    } src_t;

    typedef struct {
        int          gid;
        logic [15:0] data;
        logic        first;
        logic        last;
        int          gap;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             busy;
    logic [PTR_W-1:0] grant_id;

    logic [N-1:0] vld_r = '0;
    logic [N-1:0] fst_r = '0;
    logic [N-1:0] lst_r = '0;
    logic [15:0]  dat_r [N];
    logic [N-1:0] rdy_w;
    logic         ordy_r = 1'b1;
    logic [N-1:0] fire_s = '0;

    src_t lane_q [N][$];
    exp_t exp_q [$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_cyc = 0;

    dii_channel in_if [N] ();
    dii_channel out_if ();

    for (genvar g = 0; g < N; g++) begin : g_lane
        assign in_if[g].valid = vld_r[g];
        assign in_if[g].first = fst_r[g];
        assign in_if[g].last  = lst_r[g];
        assign in_if[g].data  = dat_r[g];
        assign rdy_w[g]       = in_if[g].ready;
    end
    assign out_if.ready = ordy_r;

    dii_packet_arbiter #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_i       (in_if),
        .out_o      (out_if),
        .busy_o     (busy),
        .grant_id_o (grant_id)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endfunction

    task automatic push_src(input int lane, input logic [15:0] d, input logic f, input logic l, input int hold);
        src_t s;
        s.data = d; s.first = f; s.last = l; s.hold = hold;
        lane_q[lane].push_back(s);
    endtask

    task automatic push_exp(input int gid, input logic [15:0] d, input logic f, input logic l, input int gap);
        exp_t e;
        e.gid = gid; e.data = d; e.first = f; e.last = l; e.gap = gap;
        exp_q.push_back(e);
    endtask

    // One clock: inputs change just after the rising edge, handshakes are sampled mid-cycle.
    task automatic step(input logic rst_v, input logic ordy_v);
        src_t s;
        @(posedge clk);
        #1;
        rst    = rst_v;
        ordy_r = ordy_v;
        for (int g = 0; g < N; g++) begin
            if (fire_s[g] && lane_q[g].size() > 0) void'(lane_q[g].pop_front());
            if (lane_q[g].size() == 0) begin
                vld_r[g] = 1'b0; fst_r[g] = 1'b0; lst_r[g] = 1'b0; dat_r[g] = '0;
            end else begin
                s = lane_q[g][0];
                if (s.hold > 0) begin
                    s.hold = s.hold - 1;
                    lane_q[g][0] = s;
                    vld_r[g] = 1'b0; fst_r[g] = 1'b0; lst_r[g] = 1'b0; dat_r[g] = '0;
                end else begin
                    vld_r[g] = 1'b1; fst_r[g] = s.first; lst_r[g] = s.last; dat_r[g] = s.data;
                end
            end
        end
        @(negedge clk);
        for (int g = 0; g < N; g++) fire_s[g] = vld_r[g] && rdy_w[g];
        #1;
    endtask

    task automatic run_until_empty(input int limit, input string name);
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < limit) begin
            step(1'b0, 1'b1);
            k++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                for (int j = 0; j < N; j++) begin
                    n_vec++;
                    if (rdy_w[j] && !(busy && int'(grant_id) == j)) begin
                        n_err++;
                        $display("FAIL ready_leak: lane %0d ready=1 with busy=%0d grant_id=%0d", j, busy, grant_id);
                    end
                end
                if (out_if.valid && out_if.ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_flit: got data 0x%0h, expected none", out_if.data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("xfer_gid", int'(grant_id), e.gid);
                        chk("xfer_data", int'(out_if.data), int'(e.data));
                        chk("xfer_first", int'(out_if.first), int'(e.first));
                        chk("xfer_last", int'(out_if.last), int'(e.last));
                        if (e.gap > 0) chk("xfer_gap", cyc - last_cyc, e.gap);
                    end
                    last_cyc = cyc;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ordy_pat [11];
        for (int g = 0; g < N; g++) dat_r[g] = '0;

        // Reset with a head flit waiting, then a 3-flit packet.
        push_src(0, 16'hA001, 1'b1, 1'b0, 0);
        push_src(0, 16'hA002, 1'b0, 1'b0, 0);
        push_src(0, 16'hA003, 1'b0, 1'b1, 0);
        push_exp(0, 16'hA001, 1'b1, 1'b0, 0);
        push_exp(0, 16'hA002, 1'b0, 1'b0, 1);
        push_exp(0, 16'hA003, 1'b0, 1'b1, 1);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1);
            chk("rst_out_valid", int'(out_if.valid), 0);
            chk("rst_ready0", int'(rdy_w[0]), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_grant_id", int'(grant_id), 0);
        end
        step(1'b0, 1'b1);
        chk("bubble_busy", int'(busy), 0);
        chk("bubble_out_valid", int'(out_if.valid), 0);
        step(1'b0, 1'b1);
        chk("first_busy", int'(busy), 1);
        chk("first_out_valid", int'(out_if.valid), 1);
        chk("first_ready0", int'(rdy_w[0]), 1);
        step(1'b0, 1'b1);
        chk("mid_busy", int'(busy), 1);
        step(1'b0, 1'b1);
        chk("last_busy", int'(busy), 1);
        step(1'b0, 1'b1);
        chk("after_busy", int'(busy), 0);
        chk("after_grant_id_hold", int'(grant_id), 0);
        chk("single_drained", exp_q.size(), 0);

        // Contention from reset: lane 0 first, one bubble, then lane 1.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        push_src(0, 16'hB001, 1'b1, 1'b0, 0);
        push_src(0, 16'hB002, 1'b0, 1'b1, 0);
        push_src(1, 16'hC001, 1'b1, 1'b0, 0);
        push_src(1, 16'hC002, 1'b0, 1'b1, 0);
        push_exp(0, 16'hB001, 1'b1, 1'b0, 0);
        push_exp(0, 16'hB002, 1'b0, 1'b1, 1);
        push_exp(1, 16'hC001, 1'b1, 1'b0, 2);
        push_exp(1, 16'hC002, 1'b0, 1'b1, 1);
        run_until_empty(20, "contention_drained");

        // Fairness from reset: single-flit packets, order 0,1,2,0,1,2 every 2 cycles.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        for (int r = 0; r < 2; r++)
            for (int g = 0; g < N; g++)
                push_src(g, 16'hD000 + 16'(r * 16 + g), 1'b1, 1'b1, 0);
        for (int r = 0; r < 2; r++)
            for (int g = 0; g < N; g++)
                push_exp(g, 16'hD000 + 16'(r * 16 + g), 1'b1, 1'b1, (r == 0 && g == 0) ? 0 : 2);
        run_until_empty(40, "fairness_drained");

        // Back-pressure plus a 2-cycle source gap, lane 1 waiting behind.
        push_src(0, 16'hE001, 1'b1, 1'b0, 0);
        push_src(0, 16'hE002, 1'b0, 1'b0, 0);
        push_src(0, 16'hE003, 1'b0, 1'b0, 2);
        push_src(0, 16'hE004, 1'b0, 1'b1, 0);
        push_src(1, 16'hF001, 1'b1, 1'b1, 0);
        push_exp(0, 16'hE001, 1'b1, 1'b0, 0);
        push_exp(0, 16'hE002, 1'b0, 1'b0, 1);
        push_exp(0, 16'hE003, 1'b0, 1'b0, 3);
        push_exp(0, 16'hE004, 1'b0, 1'b1, 1);
        push_exp(1, 16'hF001, 1'b1, 1'b1, 2);
        for (int i = 0; i < 11; i++) ordy_pat[i] = 1'b1;
        ordy_pat[1] = 1'b0;
        ordy_pat[2] = 1'b0;
        for (int i = 0; i < 11; i++) begin
            step(1'b0, ordy_pat[i]);
            if (i == 2) begin
                chk("bp_busy", int'(busy), 1);
                chk("bp_out_valid", int'(out_if.valid), 1);
                chk("bp_ready0", int'(rdy_w[0]), 0);
                chk("bp_ready1", int'(rdy_w[1]), 0);
            end
            if (i == 6) begin
                chk("gap_busy", int'(busy), 1);
                chk("gap_out_valid", int'(out_if.valid), 0);
                chk("gap_ready1", int'(rdy_w[1]), 0);
            end
        end
        chk("bp_drained", exp_q.size(), 0);

        // Reset after the first flit; the headless remainder must never be granted.
        push_src(0, 16'h6001, 1'b1, 1'b0, 0);
        push_src(0, 16'h6002, 1'b0, 1'b0, 0);
        push_src(0, 16'h6003, 1'b0, 1'b0, 0);
        push_src(0, 16'h6004, 1'b0, 1'b1, 0);
        push_exp(0, 16'h6001, 1'b1, 1'b0, 0);
        step(1'b0, 1'b1);
        chk("g_idle_busy", int'(busy), 0);
        step(1'b0, 1'b1);
        chk("g_busy", int'(busy), 1);
        step(1'b1, 1'b1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_out_valid", int'(out_if.valid), 0);
        chk("midrst_ready0", int'(rdy_w[0]), 0);
        push_src(1, 16'h7001, 1'b1, 1'b1, 0);
        push_src(2, 16'h8001, 1'b1, 1'b1, 0);
        push_exp(1, 16'h7001, 1'b1, 1'b1, 0);
        push_exp(2, 16'h8001, 1'b1, 1'b1, 2);
        step(1'b0, 1'b1);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_ready0", int'(rdy_w[0]), 0);
        step(1'b0, 1'b1);
        chk("post_rst_grant", int'(grant_id), 1);
        chk("post_rst_ready0_b", int'(rdy_w[0]), 0);
        step(1'b0, 1'b1);
        chk("post_rst_idle", int'(busy), 0);
        step(1'b0, 1'b1);
        chk("post_rst_grant2", int'(grant_id), 2);
        chk("post_rst_ready0_c", int'(rdy_w[0]), 0);
        step(1'b0, 1'b1);
        chk("nonfirst_busy", int'(busy), 0);
        chk("nonfirst_ready0", int'(rdy_w[0]), 0);
        chk("nonfirst_stalled", lane_q[0].size(), 3);
        lane_q[0].delete();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("final_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
